// File: rtl/memory_control.sv
// Two-cache coherence memory controller: arbitrates block reads, writebacks and
// upgrades, snoops the other cache and forwards dirty blocks through to RAM.
module memory_control (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  dREN,
  input  logic [1:0]  dWEN,
  input  logic [31:0] daddr0,
  input  logic [31:0] daddr1,
  input  logic [31:0] dstore0,
  input  logic [31:0] dstore1,
  input  logic [1:0]  cctrans,
  input  logic [1:0]  ccwrite,
  output logic [1:0]  dwait,
  output logic [31:0] dload0,
  output logic [31:0] dload1,
  output logic [1:0]  ccwait,
  output logic [1:0]  ccinv,
  output logic [31:0] ccsnoopaddr0,
  output logic [31:0] ccsnoopaddr1,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [3:0] {
    IDLE, ARB, SNOOP, FWD0, FWD1, RD0, RD1, WB0, WB1, INV
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'b10;

  state_t state_q, state_d;
  logic   req_q, req_d;
  logic   last_q, last_d;

  logic [1:0]        req_any;
  logic              req_sel;
  logic              oth;
  logic              access;
  logic [31:0]       daddr_req;
  logic [31:0]       dstore_req;
  logic [31:0]       dstore_oth;
  logic [31:0]       base;
  logic [1:0][31:0]  dload_v;
  logic [1:0][31:0]  snoop_v;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_any[gi] = dREN[gi] | dWEN[gi];
    end
  endgenerate

  // Tie goes to the cache opposite the pointer; otherwise the lone requester.
  assign req_sel    = (req_any == 2'b11) ? ~last_q : req_any[1];
  assign oth        = ~req_q;
  assign access     = (ramstate == RAM_ACCESS);
  assign daddr_req  = req_q ? daddr1  : daddr0;
  assign dstore_req = req_q ? dstore1 : dstore0;
  assign dstore_oth = req_q ? dstore0 : dstore1;
  assign base       = {daddr_req[31:3], 3'b000};

  assign dload0       = dload_v[0];
  assign dload1       = dload_v[1];
  assign ccsnoopaddr0 = snoop_v[0];
  assign ccsnoopaddr1 = snoop_v[1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    last_d   = last_q;
    dwait    = 2'b11;
    ccwait   = 2'b00;
    ccinv    = 2'b00;
    dload_v  = '0;
    snoop_v  = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;

    case (state_q)
      IDLE: begin
        if (|req_any) state_d = ARB;
      end
      ARB: begin
        req_d = req_sel;
        if (|req_any) last_d = ~last_q;
        if (dWEN[req_sel] && !ccwrite[req_sel])
          state_d = WB0;
        else if (ccwrite[req_sel] && cctrans[req_sel] && !dREN[req_sel])
          state_d = INV;
        else if (dREN[req_sel])
          state_d = SNOOP;
        else if (dWEN[req_sel])
          state_d = WB0;
        else
          state_d = IDLE;
      end
      SNOOP: begin
        ccwait[oth]  = 1'b1;
        snoop_v[oth] = base;
        ccinv[oth]   = ccwrite[req_q];
        state_d      = ccwrite[oth] ? FWD0 : RD0;
      end
      FWD0, FWD1: begin
        // Dirty data from the snooped cache is written back and forwarded at once.
        ccwait[oth]    = 1'b1;
        snoop_v[oth]   = base;
        ramWEN         = 1'b1;
        ramstore       = dstore_oth;
        ramaddr        = base + ((state_q == FWD1) ? 32'd4 : 32'd0);
        dload_v[req_q] = dstore_oth;
        dwait[req_q]   = ~access;
        if (access) state_d = (state_q == FWD0) ? FWD1 : IDLE;
      end
      RD0, RD1: begin
        ramREN         = 1'b1;
        ramaddr        = base + ((state_q == RD1) ? 32'd4 : 32'd0);
        dload_v[req_q] = ramload;
        dwait[req_q]   = ~access;
        if (access) state_d = (state_q == RD0) ? RD1 : IDLE;
      end
      WB0, WB1: begin
        ramWEN       = 1'b1;
        ramaddr      = daddr_req;
        ramstore     = dstore_req;
        dwait[req_q] = ~access;
        if (access) state_d = (state_q == WB0) ? WB1 : IDLE;
      end
      INV: begin
        ccwait[oth]  = 1'b1;
        ccinv[oth]   = 1'b1;
        snoop_v[oth] = daddr_req;
        dwait[req_q] = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_control.sv
// Scoreboarded random and directed bench for memory_control with a RAM responder.
module tb_memory_control;

  localparam int K_RD  = 0;
  localparam int K_WB  = 1;
  localparam int K_UPG = 2;
  localparam int B_RD  = 0;
  localparam int B_WB  = 1;
  localparam int B_FWD = 2;
  localparam int B_INV = 3;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  dREN, dWEN, cctrans, ccwrite;
  logic [31:0] daddr_b [2];
  logic [31:0] dstore_b [2];
  logic [1:0]  dwait, ccwait, ccinv;
  logic [31:0] dload0, dload1, ccsnoopaddr0, ccsnoopaddr1;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  always #5 CLK = ~CLK;

  memory_control dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN),
    .daddr0(daddr_b[0]), .daddr1(daddr_b[1]),
    .dstore0(dstore_b[0]), .dstore1(dstore_b[1]),
    .cctrans(cctrans), .ccwrite(ccwrite),
    .dwait(dwait), .dload0(dload0), .dload1(dload1),
    .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr0(ccsnoopaddr0), .ccsnoopaddr1(ccsnoopaddr1),
    .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  typedef struct {
    int          c;
    int          kind;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] mem_m   [1024];
  logic [31:0] ram_mem [1024];
  bit          last_m;
  int          checks = 0;
  int          errors = 0;

  bit          exp_sn_inv;
  logic [31:0] exp_sn_addr;
  int          exp_sn_req;

  int          en [2];
  int          kind [2];
  logic [31:0] caddr [2];
  logic [31:0] w0 [2];
  logic [31:0] w1 [2];
  bit          excl [2];
  bit          sup_dirty;
  logic [31:0] s0, s1;

  bit ram_hold;
  int err_n;
  int lat;
  int err_seen;

  assign ramload = ram_mem[ramaddr[11:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dload_of(input int c);
    return (c == 1) ? dload1 : dload0;
  endfunction

  function automatic logic [31:0] snp_of(input int c);
    return (c == 1) ? ccsnoopaddr1 : ccsnoopaddr0;
  endfunction

  // RAM responder: random BUSY latency, optional forced ERROR or indefinite hold.
  initial begin
    ramstate = 2'b00;
    lat = 0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST || !(ramREN || ramWEN)) ramstate = 2'b00;
      else if (ram_hold) ramstate = 2'b01;
      else if (err_n > 0) begin ramstate = 2'b11; err_n--; end
      else if (lat > 0) begin ramstate = 2'b01; lat--; end
      else begin ramstate = 2'b10; lat = $urandom_range(0, 2); end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (!RST && ramWEN && ramstate == 2'b10) ram_mem[ramaddr[11:2]] = ramstore;
    end
  end

  // Monitor: every completed word is popped from the scoreboard and compared.
  initial begin
    beat_t e;
    int o;
    logic [1:0] mask;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        if (ramREN || ramWEN) chk("ren_and_wen", {31'd0, ramREN & ramWEN}, 32'd0);
        if ((ramREN || ramWEN) && ramstate != 2'b10) chk("stall_dwait", dwait, 2'b11);
        if (ramWEN && ramstate == 2'b11) err_seen++;
        if (dwait != 2'b11) begin
          if (sb.size() == 0) chk("unexpected_beat", dwait, 2'b11);
          else begin
            e = sb.pop_front();
            o = 1 - e.c;
            mask = 2'b01 << o;
            chk("beat_dwait", dwait, (e.c == 1) ? 2'b01 : 2'b10);
            case (e.kind)
              B_RD: begin
                chk("rd_ren", ramREN, 1);
                chk("rd_wen", ramWEN, 0);
                chk("rd_addr", ramaddr, e.addr);
                chk("rd_dload", dload_of(e.c), e.rd);
                chk("rd_ccinv", ccinv, 0);
              end
              B_WB: begin
                chk("wb_wen", ramWEN, 1);
                chk("wb_ren", ramREN, 0);
                chk("wb_addr", ramaddr, e.addr);
                chk("wb_data", ramstore, e.wd);
              end
              B_FWD: begin
                chk("fwd_wen", ramWEN, 1);
                chk("fwd_addr", ramaddr, e.addr);
                chk("fwd_data", ramstore, e.wd);
                chk("fwd_dload", dload_of(e.c), e.rd);
                chk("fwd_ccwait", ccwait, mask);
                chk("fwd_snpaddr", snp_of(o), e.addr & ~32'h7);
              end
              default: begin
                chk("inv_ccinv", ccinv, mask);
                chk("inv_ccwait", ccwait, mask);
                chk("inv_snpaddr", snp_of(o), e.addr);
                chk("inv_strobe", {30'd0, ramREN, ramWEN}, 0);
              end
            endcase
          end
        end else if (ccwait != 2'b00 && !ramREN && !ramWEN) begin
          o = 1 - exp_sn_req;
          mask = 2'b01 << o;
          chk("sn_ccwait", ccwait, mask);
          chk("sn_ccinv", ccinv, exp_sn_inv ? mask : 2'b00);
          chk("sn_addr", snp_of(o), exp_sn_addr);
        end else if (ccwait == 2'b00 && !ramREN && !ramWEN) begin
          chk("idle_buses", ramaddr | ramstore | dload0 | dload1 | ccsnoopaddr0 |
              ccsnoopaddr1 | {30'd0, ccinv}, 0);
        end
      end
    end
  end

  // Reference: serve requesters in pointer order, each by its block-level effect.
  task automatic push_model();
    int first, n, c;
    logic [31:0] b;
    if (en[0] != 0 && en[1] != 0) begin first = last_m ? 0 : 1; n = 2; end
    else begin first = (en[0] != 0) ? 0 : 1; n = 1; end
    for (int k = 0; k < n; k++) begin
      c = (k == 0) ? first : 1 - first;
      last_m = ~last_m;
      case (kind[c])
        K_RD: begin
          b = caddr[c] & ~32'h7;
          exp_sn_req = c; exp_sn_inv = excl[c]; exp_sn_addr = b;
          if (sup_dirty) begin
            mem_m[b[11:2]] = s0;
            mem_m[b[11:2] + 10'd1] = s1;
            sb.push_back('{c, B_FWD, b, s0, s0});
            sb.push_back('{c, B_FWD, b + 32'd4, s1, s1});
          end else begin
            sb.push_back('{c, B_RD, b, 32'd0, mem_m[b[11:2]]});
            sb.push_back('{c, B_RD, b + 32'd4, 32'd0, mem_m[b[11:2] + 10'd1]});
          end
        end
        K_WB: begin
          b = caddr[c];
          mem_m[b[11:2]] = w0[c];
          mem_m[b[11:2] + 10'd1] = w1[c];
          sb.push_back('{c, B_WB, b, w0[c], 32'd0});
          sb.push_back('{c, B_WB, b + 32'd4, w1[c], 32'd0});
        end
        default: sb.push_back('{c, B_INV, caddr[c], 32'd0, 32'd0});
      endcase
    end
  endtask

  task automatic set_cmd(input int c, input int k, input logic [31:0] a,
                         input logic [31:0] d0, input logic [31:0] d1, input bit ex);
    en[c] = 1; kind[c] = k; caddr[c] = a; w0[c] = d0; w1[c] = d1; excl[c] = ex;
  endtask

  // Cache-side driver: raise requests, advance words on dwait low, drop when done.
  task automatic run_cmds();
    int cnt [2];
    int need [2];
    bit adv [2];
    bit done;
    int cyc;
    push_model();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; adv[i] = 0;
      need[i] = (en[i] == 0) ? 0 : ((kind[i] == K_UPG) ? 1 : 2);
      if (en[i] != 0) begin
        daddr_b[i] = caddr[i];
        case (kind[i])
          K_RD: begin
            dREN[i] = 1'b1; cctrans[i] = 1'b1; ccwrite[i] = excl[i];
            ccwrite[1-i] = sup_dirty; dstore_b[1-i] = s0;
          end
          K_WB: begin dWEN[i] = 1'b1; dstore_b[i] = w0[i]; end
          default: begin dWEN[i] = 1'b1; cctrans[i] = 1'b1; ccwrite[i] = 1'b1; end
        endcase
      end
    end
    done = 0;
    cyc = 0;
    while (!done && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      for (int i = 0; i < 2; i++)
        if (cnt[i] < need[i] && dwait[i] == 1'b0) begin cnt[i]++; adv[i] = 1; end
      @(posedge CLK);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (adv[i]) begin
          if (cnt[i] == need[i]) begin
            dREN[i] = 1'b0; dWEN[i] = 1'b0; cctrans[i] = 1'b0; ccwrite[i] = 1'b0;
            if (kind[i] == K_RD) ccwrite[1-i] = 1'b0;
          end else if (kind[i] == K_WB) begin
            daddr_b[i] = caddr[i] + 32'd4; dstore_b[i] = w1[i];
          end else if (kind[i] == K_RD) begin
            dstore_b[1-i] = s1;
          end
          adv[i] = 0;
        end
      end
      done = (cnt[0] == need[0]) && (cnt[1] == need[1]);
    end
    chk("txn_done", {31'd0, done}, 1);
    en[0] = 0; en[1] = 0; sup_dirty = 0;
  endtask

  initial begin
    logic [31:0] v;
    int r, c, k;
    RST = 1'b1;
    dREN = 0; dWEN = 0; cctrans = 0; ccwrite = 0;
    daddr_b[0] = 0; daddr_b[1] = 0; dstore_b[0] = 0; dstore_b[1] = 0;
    en[0] = 0; en[1] = 0; sup_dirty = 0; s0 = 0; s1 = 0;
    ram_hold = 0; err_n = 0; err_seen = 0;
    exp_sn_inv = 0; exp_sn_addr = 0; exp_sn_req = 0;
    last_m = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      v = $urandom;
      mem_m[i] = v; ram_mem[i] = v;
    end
    mem_m[32'h40] = 32'hA; ram_mem[32'h40] = 32'hA;
    mem_m[32'h41] = 32'hB; ram_mem[32'h41] = 32'hB;

    repeat (3) begin
      @(negedge CLK);
      chk("rst_dwait", dwait, 2'b11);
      chk("rst_outs", dload0 | dload1 | ccsnoopaddr0 | ccsnoopaddr1 | ramaddr | ramstore |
          {26'd0, ccwait, ccinv, ramREN, ramWEN}, 0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Simultaneous writebacks straight after reset: cache 0 first.
    set_cmd(0, K_WB, 32'h500, 32'h1111_0000, 32'h1111_0001, 0);
    set_cmd(1, K_WB, 32'h600, 32'h2222_0000, 32'h2222_0001, 0);
    run_cmds();
    $display("txn: both dWEN tie served");

    set_cmd(0, K_RD, 32'h100, 0, 0, 0);
    run_cmds();
    $display("txn: cache0 read 0x100 from RAM");

    set_cmd(0, K_RD, 32'h100, 0, 0, 0);
    sup_dirty = 1; s0 = 32'h11; s1 = 32'h22;
    run_cmds();
    $display("txn: cache0 read 0x100 forwarded from dirty cache1");

    set_cmd(1, K_UPG, 32'h208, 0, 0, 1);
    run_cmds();
    $display("txn: cache1 upgrade 0x208");

    err_n = 3; lat = 0; err_seen = 0;
    set_cmd(0, K_WB, 32'h400, 32'h55, 32'h66, 0);
    run_cmds();
    chk("err_cycles", err_seen, 3);
    $display("txn: writeback through 3 ERROR cycles");

    // Reset mid-read while RAM is busy.
    ram_hold = 1;
    exp_sn_req = 0; exp_sn_inv = 0; exp_sn_addr = 32'h300;
    daddr_b[0] = 32'h300; dREN[0] = 1'b1; cctrans[0] = 1'b1;
    r = 0;
    while (!ramREN && r < 50) begin @(negedge CLK); r++; end
    chk("rd0_reached", {31'd0, ramREN}, 1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_ren", {31'd0, ramREN}, 0);
    chk("rst_mid_wen", {31'd0, ramWEN}, 0);
    chk("rst_mid_dwait", dwait, 2'b11);
    dREN = 0; cctrans = 0;
    @(posedge CLK); #1;
    RST = 1'b0; ram_hold = 0; last_m = 1'b1;
    sb.delete();
    @(posedge CLK); #1;
    $display("txn: reset during RD0 aborted");

    set_cmd(0, K_UPG, 32'h700, 0, 0, 1);
    set_cmd(1, K_UPG, 32'h704, 0, 0, 1);
    run_cmds();
    $display("txn: simultaneous upgrades serialized");

    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        k = (r == 0) ? K_WB : K_UPG;
        set_cmd(0, k, 32'($urandom_range(0, 511)) << 3, $urandom, $urandom, 1);
        set_cmd(1, k, 32'($urandom_range(0, 511)) << 3, $urandom, $urandom, 1);
        excl[0] = (k == K_UPG); excl[1] = (k == K_UPG);
      end else begin
        c = $urandom_range(0, 1);
        k = $urandom_range(0, 2);
        set_cmd(c, k, 32'($urandom_range(0, 511)) << 3, $urandom, $urandom,
                bit'($urandom_range(0, 1)));
        if (k == K_UPG) excl[c] = 1;
        if (k == K_RD) begin
          sup_dirty = bit'($urandom_range(0, 1)); s0 = $urandom; s1 = $urandom;
        end
      end
      run_cmds();
      $display("txn %0d: kind=%0d pair=%0d", t, k, (r < 2));
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end

    repeat (3) @(posedge CLK);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
